// File: rtl/ram_rw_tester.sv
// Self-checking single-port RAM sequencer: writes a pattern over DEPTH words, reads it back
// through a latency-matched compare pipe and reports pass, error count and first failing address.
module ram_rw_tester #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 5,
   parameter int DEPTH      = 32,
   parameter int RD_LATENCY = 1,
   parameter int ERR_W      = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   input  logic [1:0]        pat_sel,
   input  logic [DATA_W-1:0] seed,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam int                DRAIN_W    = $clog2(RD_LATENCY + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LATENCY - 1);

   logic [2:0]         state;
   logic [ADDR_W-1:0]  addr;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [DATA_W-1:0]  seed_q;
   logic [1:0]         pat_q;
   logic [DATA_W-1:0]  cur_pat;
   logic               err_seen;
   logic               mismatch;
   logic               last_compare;

   logic               pipe_vld  [RD_LATENCY];
   logic [ADDR_W-1:0]  pipe_addr [RD_LATENCY];
   logic [DATA_W-1:0]  pipe_exp  [RD_LATENCY];

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] sel,
                                                 input logic [DATA_W-1:0] sd,
                                                 input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] sum;
      logic [DATA_W-1:0] alt;
      sum = DATA_W'(a) + sd;
      // Alternating 0101.. for even addresses, 1010.. for odd ones
      for (int i = 0; i < DATA_W; i++) begin
         alt[i] = (i[0] == a[0]);
      end
      case (sel)
         2'd1:    return ~sum;
         2'd2:    return alt;
         default: return sum;
      endcase
   endfunction

   assign cur_pat     = pattern(pat_q, seed_q, addr);
   assign ram_en      = (state == S_WRITE) || (state == S_READ);
   assign ram_we      = (state == S_WRITE);
   assign ram_addr    = ram_en ? addr : '0;
   assign ram_wr_data = (state == S_WRITE) ? cur_pat : '0;
   assign busy        = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= S_IDLE;
         addr      <= '0;
         drain_cnt <= '0;
         seed_q    <= '0;
         pat_q     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  seed_q <= seed;
                  pat_q  <= pat_sel;
                  addr   <= '0;
                  state  <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (addr == LAST_ADDR) begin
                  addr  <= '0;
                  state <= S_READ;
               end else begin
                  addr <= addr + ADDR_W'(1);
               end
            end
            S_READ: begin
               if (addr == LAST_ADDR) begin
                  addr      <= '0;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end else begin
                  addr <= addr + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt + DRAIN_W'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Expected word and address travel alongside the RAM read so they meet the returned data
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_vld[i]  <= 1'b0;
            pipe_addr[i] <= '0;
            pipe_exp[i]  <= '0;
         end
      end else begin
         pipe_vld[0]  <= (state == S_READ);
         pipe_addr[0] <= addr;
         pipe_exp[0]  <= cur_pat;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
         end
      end
   end

   assign mismatch     = pipe_vld[RD_LATENCY-1] && (ram_rd_data != pipe_exp[RD_LATENCY-1]);
   assign last_compare = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);

   // pass must include a mismatch found on the very edge that enters DONE
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         err_cnt        <= '0;
         first_err_addr <= '0;
         err_seen       <= 1'b0;
         pass           <= 1'b0;
         done           <= 1'b0;
      end else begin
         done <= (state == S_DONE);
         if ((state == S_IDLE) && start) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            pass           <= 1'b0;
         end else if (mismatch) begin
            if (err_cnt != '1) begin
               err_cnt <= err_cnt + ERR_W'(1);
            end
            if (!err_seen) begin
               first_err_addr <= pipe_addr[RD_LATENCY-1];
               err_seen       <= 1'b1;
            end
         end
         if (last_compare) begin
            pass <= (err_cnt == '0) && !mismatch;
         end
      end
   end

endmodule

// File: tb/tb_ram_rw_tester.sv
// Bench for ram_rw_tester: two instances (latency 1 / 8-bit errors, latency 2 / 4-bit errors),
// each with its own RAM model, checked every cycle against a run-schedule model.
module tb_ram_rw_tester;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
   localparam int NDUT   = 2;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n = 1'b0;
   logic              start [NDUT];
   logic [1:0]        pat_sel;
   logic [DATA_W-1:0] seed;
   logic              ram_en [NDUT];
   logic              ram_we [NDUT];
   logic [ADDR_W-1:0] ram_addr [NDUT];
   logic [DATA_W-1:0] ram_wr_data [NDUT];
   logic [DATA_W-1:0] ram_rd_data [NDUT];
   logic              busy [NDUT];
   logic              done [NDUT];
   logic              pass [NDUT];
   logic [7:0]        err_cnt [NDUT];
   logic [ADDR_W-1:0] first_err_addr [NDUT];
   int                fault_mode [NDUT];

   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   bit                run_on [NDUT];
   int                run_k [NDUT];
   logic [1:0]        m_pat [NDUT];
   logic [7:0]        m_seed [NDUT];
   int                m_fault [NDUT];
   logic [7:0]        wr_log [NDUT][DEPTH];

   always #5 sys_clk = ~sys_clk;

   function automatic int rl_of(input int g);
      return (g == 0) ? 1 : 2;
   endfunction

   function automatic int errmax_of(input int g);
      return (g == 0) ? 255 : 15;
   endfunction

   function automatic logic [7:0] corrupt(input int g, input logic [ADDR_W-1:0] a,
                                          input logic [7:0] d);
      if (fault_mode[g] == 2) return 8'h00;
      if (fault_mode[g] == 1 && a == 5'd5) return 8'h00;
      return d;
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : gen_dut
      localparam int G_RL   = (g == 0) ? 1 : 2;
      localparam int G_ERRW = (g == 0) ? 8 : 4;
      logic [G_ERRW-1:0] ec;
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_stage [G_RL];

      ram_rw_tester #(
         .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
         .RD_LATENCY(G_RL), .ERR_W(G_ERRW)
      ) dut (
         .sys_clk(sys_clk),
         .sys_rst_n(sys_rst_n),
         .start(start[g]),
         .pat_sel(pat_sel),
         .seed(seed),
         .ram_en(ram_en[g]),
         .ram_we(ram_we[g]),
         .ram_addr(ram_addr[g]),
         .ram_wr_data(ram_wr_data[g]),
         .ram_rd_data(ram_rd_data[g]),
         .busy(busy[g]),
         .done(done[g]),
         .pass(pass[g]),
         .err_cnt(ec),
         .first_err_addr(first_err_addr[g])
      );

      assign err_cnt[g]     = 8'(ec);
      assign ram_rd_data[g] = rd_stage[G_RL-1];

      // Synchronous RAM with G_RL clocks of read latency and an optional read-side fault
      always @(posedge sys_clk) begin
         if (ram_en[g] && ram_we[g]) mem[ram_addr[g]] <= ram_wr_data[g];
         rd_stage[0] <= (ram_en[g] && !ram_we[g]) ? corrupt(g, ram_addr[g], mem[ram_addr[g]]) : 8'h00;
         for (int i = 1; i < G_RL; i++) rd_stage[i] <= rd_stage[i-1];
      end
   end

   function automatic logic [7:0] pat_f(input logic [1:0] p, input logic [7:0] s, input int a);
      logic [7:0] sum;
      sum = 8'(a) + s;
      case (p)
         2'd1:    return ~sum;
         2'd2:    return (a % 2 == 0) ? 8'h55 : 8'hAA;
         default: return sum;
      endcase
   endfunction

   function automatic bit bad_addr(input int g, input int a);
      logic [7:0] want;
      logic [7:0] got;
      want = pat_f(m_pat[g], m_seed[g], a);
      got  = want;
      if (m_fault[g] == 2 || (m_fault[g] == 1 && a == 5)) got = 8'h00;
      return got != want;
   endfunction

   // Word a is read in run cycle DEPTH+a; its result is visible RL+1 cycles later
   function automatic int errs_upto(input int g, input int t);
      int n;
      n = 0;
      for (int a = 0; a < DEPTH; a++)
         if (DEPTH + a + rl_of(g) + 1 <= t && bad_addr(g, a)) n++;
      return (n > errmax_of(g)) ? errmax_of(g) : n;
   endfunction

   function automatic int first_upto(input int g, input int t);
      for (int a = 0; a < DEPTH; a++)
         if (DEPTH + a + rl_of(g) + 1 <= t && bad_addr(g, a)) return a;
      return 0;
   endfunction

   // Run bookkeeping: a start is accepted only while the instance is idle
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int g = 0; g < NDUT; g++) run_on[g] = 1'b0;
      end else begin
         cyc = cyc + 1;
         for (int g = 0; g < NDUT; g++) begin
            if (start[g] && (!run_on[g] || cyc - run_k[g] >= 2*DEPTH + rl_of(g) + 2)) begin
               run_on[g]  = 1'b1;
               run_k[g]   = cyc;
               m_pat[g]   = pat_sel;
               m_seed[g]  = seed;
               m_fault[g] = fault_mode[g];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compareDut(input int g);
      logic       e_en, e_we, e_busy, e_done, e_pass;
      logic [4:0] e_addr;
      logic [7:0] e_wd;
      int         e_err, e_first, t, rl;
      e_en = 0; e_we = 0; e_busy = 0; e_done = 0; e_pass = 0;
      e_addr = '0; e_wd = '0; e_err = 0; e_first = 0;
      rl = rl_of(g);
      if (sys_rst_n && run_on[g]) begin
         t = cyc - run_k[g];
         if (t < DEPTH) begin
            e_en = 1; e_we = 1; e_addr = 5'(t); e_wd = pat_f(m_pat[g], m_seed[g], t);
         end else if (t < 2*DEPTH) begin
            e_en = 1; e_addr = 5'(t - DEPTH);
         end
         e_busy  = (t < 2*DEPTH + rl);
         e_done  = (t == 2*DEPTH + rl + 1);
         e_err   = errs_upto(g, t);
         e_first = first_upto(g, t);
         e_pass  = (t >= 2*DEPTH + rl) && (e_err == 0);
      end
      checkOutput($sformatf("d%0d_ram_en", g), 32'(ram_en[g]), 32'(e_en));
      checkOutput($sformatf("d%0d_ram_we", g), 32'(ram_we[g]), 32'(e_we));
      checkOutput($sformatf("d%0d_ram_addr", g), 32'(ram_addr[g]), 32'(e_addr));
      checkOutput($sformatf("d%0d_ram_wr_data", g), 32'(ram_wr_data[g]), 32'(e_wd));
      checkOutput($sformatf("d%0d_busy", g), 32'(busy[g]), 32'(e_busy));
      checkOutput($sformatf("d%0d_done", g), 32'(done[g]), 32'(e_done));
      checkOutput($sformatf("d%0d_pass", g), 32'(pass[g]), 32'(e_pass));
      checkOutput($sformatf("d%0d_err_cnt", g), 32'(err_cnt[g]), 32'(e_err));
      checkOutput($sformatf("d%0d_first_err_addr", g), 32'(first_err_addr[g]), 32'(e_first));
      if (ram_en[g] && ram_we[g]) wr_log[g][ram_addr[g]] = ram_wr_data[g];
   endtask

   initial begin
      forever begin
         @(negedge sys_clk);
         #1;
         for (int g = 0; g < NDUT; g++) compareDut(g);
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Called at a negedge; start is sampled on the following rising edge
   task automatic applyStimulus(input int g, input logic [1:0] p, input logic [7:0] s,
                                output int k);
      pat_sel  = p;
      seed     = s;
      start[g] = 1'b1;
      k        = cyc + 1;
      @(negedge sys_clk);
      start[g] = 1'b0;
   endtask

   task automatic waitDone(input int g, input int k, output int lat);
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge sys_clk);
         if (done[g] === 1'b1) begin
            lat = cyc - k;
            return;
         end
      end
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL d%0d_done_timeout: got no done, expected done within 300 cycles", g);
   endtask

   task automatic countDone(input int g, input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge sys_clk);
         if (done[g] === 1'b1) cnt++;
      end
   endtask

   initial begin
      int k, lat, extra;
      for (int g = 0; g < NDUT; g++) begin
         start[g] = 1'b0;
         fault_mode[g] = 0;
      end
      pat_sel = 2'd0;
      seed    = 8'h00;
      waitCycles(3);
      checkOutput("reset_busy", 32'(busy[0]), 0);
      checkOutput("reset_pass", 32'(pass[1]), 0);
      checkOutput("reset_ram_en", 32'(ram_en[0]), 0);
      sys_rst_n = 1'b1;
      waitCycles(2);

      $display("[TB] ideal RAM, seed 0, pattern 0");
      applyStimulus(0, 2'd0, 8'h00, k);
      waitDone(0, k, lat);
      checkOutput("t1_latency", lat, 66);
      checkOutput("t1_wr_addr5", 32'(wr_log[0][5]), 32'h05);
      checkOutput("t1_wr_addr31", 32'(wr_log[0][31]), 32'h1F);
      checkOutput("t1_pass", 32'(pass[0]), 1);
      checkOutput("t1_err_cnt", 32'(err_cnt[0]), 0);
      checkOutput("t1_first_err_addr", 32'(first_err_addr[0]), 0);
      waitCycles(3);

      $display("[TB] RAM returns 0x00 at address 5");
      fault_mode[0] = 1;
      applyStimulus(0, 2'd0, 8'h00, k);
      waitDone(0, k, lat);
      checkOutput("t2_err_cnt", 32'(err_cnt[0]), 1);
      checkOutput("t2_first_err_addr", 32'(first_err_addr[0]), 5);
      checkOutput("t2_pass", 32'(pass[0]), 0);
      fault_mode[0] = 0;
      waitCycles(3);

      $display("[TB] read latency 2, seed F0, pattern 1");
      applyStimulus(1, 2'd1, 8'hF0, k);
      waitDone(1, k, lat);
      checkOutput("t3_latency", lat, 67);
      checkOutput("t3_wr_addr16", 32'(wr_log[1][16]), 32'hFF);
      checkOutput("t3_wr_addr0", 32'(wr_log[1][0]), 32'h0F);
      checkOutput("t3_pass", 32'(pass[1]), 1);
      waitCycles(3);

      $display("[TB] pattern 2 against stuck-at-0 read data, 4-bit error counter");
      fault_mode[1] = 2;
      applyStimulus(1, 2'd2, 8'h00, k);
      waitDone(1, k, lat);
      checkOutput("t4_wr_addr0", 32'(wr_log[1][0]), 32'h55);
      checkOutput("t4_wr_addr1", 32'(wr_log[1][1]), 32'hAA);
      checkOutput("t4_err_cnt", 32'(err_cnt[1]), 15);
      checkOutput("t4_first_err_addr", 32'(first_err_addr[1]), 0);
      checkOutput("t4_pass", 32'(pass[1]), 0);
      fault_mode[1] = 0;
      waitCycles(3);

      $display("[TB] start pulsed during READ");
      applyStimulus(0, 2'd3, 8'h21, k);
      waitCycles(40);
      start[0] = 1'b1;
      waitCycles(1);
      start[0] = 1'b0;
      waitDone(0, k, lat);
      checkOutput("t5_latency", lat, 66);
      countDone(0, 80, extra);
      checkOutput("t5_extra_done", extra, 0);
      checkOutput("t5_pass", 32'(pass[0]), 1);

      $display("[TB] reset asserted mid-WRITE");
      applyStimulus(0, 2'd0, 8'h07, k);
      waitCycles(10);
      sys_rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_ram_en", 32'(ram_en[0]), 0);
      checkOutput("t5_rst_ram_addr", 32'(ram_addr[0]), 0);
      checkOutput("t5_rst_ram_wr_data", 32'(ram_wr_data[0]), 0);
      checkOutput("t5_rst_busy", 32'(busy[0]), 0);
      waitCycles(2);
      sys_rst_n = 1'b1;
      countDone(0, 80, extra);
      checkOutput("t5_no_done_after_reset", extra, 0);
      applyStimulus(0, 2'd0, 8'h07, k);
      waitDone(0, k, lat);
      checkOutput("t5_clean_pass", 32'(pass[0]), 1);

      $display("[TB] back-to-back runs with different seeds");
      fault_mode[0] = 1;
      waitCycles(2);
      applyStimulus(0, 2'd0, 8'h3C, k);
      waitDone(0, k, lat);
      checkOutput("t6a_err_cnt", 32'(err_cnt[0]), 1);
      checkOutput("t6a_first_err_addr", 32'(first_err_addr[0]), 5);
      checkOutput("t6a_pass", 32'(pass[0]), 0);
      fault_mode[0] = 0;
      applyStimulus(0, 2'd1, 8'h11, k);
      waitDone(0, k, lat);
      checkOutput("t6b_latency", lat, 66);
      checkOutput("t6b_wr_addr2", 32'(wr_log[0][2]), 32'hEC);
      checkOutput("t6b_err_cnt", 32'(err_cnt[0]), 0);
      checkOutput("t6b_first_err_addr", 32'(first_err_addr[0]), 0);
      checkOutput("t6b_pass", 32'(pass[0]), 1);
      waitCycles(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
